// File: rtl/key_refresh_scheduler.sv
// Single-clock key refresh sequencer: 1 s time base, epoch-driven hash requests, display window.
// Optional macro HASH_TIMEOUT_EN adds a WAIT-state watchdog that drives the sticky hash_err flag.
module key_refresh_scheduler #(
    parameter int TICK_DIV      = 1000000,
    parameter int KEY_PERIOD    = 30,
    parameter int DISPLAY_TICKS = 5,
    parameter int HASH_TIMEOUT  = 64
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        button_pulse,
    input  logic [15:0] student_id,
    input  logic        hash_done,
    input  logic [15:0] hash_result,
    output logic        hash_start,
    output logic [15:0] hash_time,
    output logic [15:0] hash_id,
    output logic [15:0] key_out,
    output logic        key_valid,
    output logic        display_en,
    output logic [15:0] cur_time,
    output logic        epoch_tick,
    output logic        hash_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = (KEY_PERIOD > 1) ? $clog2(KEY_PERIOD) : 1;
    localparam int DW = (DISPLAY_TICKS > 0) ? $clog2(DISPLAY_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [EW-1:0] EPOCH_MAX = EW'(KEY_PERIOD - 1);
    localparam logic [DW-1:0] DISP_LOAD = DW'(DISPLAY_TICKS);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // time base
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   time_q, time_d;
    logic [EW-1:0] epoch_q, epoch_d;
    logic          sec_tick, epoch_wrap;
    logic          epoch_tick_q;

    // request sequencer
    state_t        state_q;
    logic          pending_q;
    logic          hash_start_q;
    logic [15:0]   hash_time_q, hash_id_q;
    logic [15:0]   key_q;
    logic          key_valid_q;

    // display window
    logic [DW-1:0] disp_cnt_q, disp_cnt_d;
    logic          disp_en_q, disp_en_d;

    always_comb begin
        sec_tick   = (pre_q == PRE_MAX);
        pre_d      = sec_tick ? '0 : pre_q + PW'(1);
        time_d     = sec_tick ? time_q + 16'd1 : time_q;
        epoch_wrap = sec_tick && (epoch_q == EPOCH_MAX);
        epoch_d    = epoch_q;
        if (sec_tick) begin
            epoch_d = epoch_wrap ? '0 : epoch_q + EW'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            pre_q        <= '0;
            time_q       <= '0;
            epoch_q      <= '0;
            epoch_tick_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            time_q       <= time_d;
            epoch_q      <= epoch_d;
            epoch_tick_q <= epoch_wrap;
        end
    end

`ifdef HASH_TIMEOUT_EN
    localparam int WW = (HASH_TIMEOUT > 1) ? $clog2(HASH_TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_MAX = WW'(HASH_TIMEOUT - 1);

    logic [WW-1:0] wd_q;
    logic          hash_err_q;
    logic          wd_expired;

    assign wd_expired = (state_q == WAIT) && !hash_done && (wd_q == WD_MAX);

    // Watchdog restarts from zero every time WAIT is entered.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wd_q       <= '0;
            hash_err_q <= 1'b0;
        end else begin
            if (state_q == WAIT && !hash_done && !wd_expired) begin
                wd_q <= wd_q + WW'(1);
            end else begin
                wd_q <= '0;
            end
            if (state_q == WAIT && hash_done) begin
                hash_err_q <= 1'b0;
            end else if (wd_expired) begin
                hash_err_q <= 1'b1;
            end
        end
    end

    assign hash_err = hash_err_q;
`else
    logic wd_expired;

    assign wd_expired = 1'b0;
    assign hash_err   = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b1;
            hash_start_q <= 1'b0;
            hash_time_q  <= '0;
            hash_id_q    <= '0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
        end else begin
            hash_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q      <= REQ;
                        hash_start_q <= 1'b1;
                        hash_time_q  <= time_d;
                        hash_id_q    <= student_id;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (hash_done) begin
                        state_q     <= IDLE;
                        key_q       <= hash_result;
                        key_valid_q <= 1'b1;
                    end else if (wd_expired) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A request issued on this edge already carries the latest time, so it absorbs
            // a coincident epoch; epochs seen while busy collapse into one pending request.
            if (state_q == IDLE && pending_q) begin
                pending_q <= 1'b0;
            end else if (epoch_wrap) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_comb begin
        disp_cnt_d = disp_cnt_q;
        disp_en_d  = disp_en_q;
        if (button_pulse && key_valid_q) begin
            disp_cnt_d = DISP_LOAD;
            disp_en_d  = (DISPLAY_TICKS != 0);
        end else if (sec_tick && disp_cnt_q != '0) begin
            disp_cnt_d = disp_cnt_q - DW'(1);
            if (disp_cnt_q == DW'(1)) begin
                disp_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            disp_cnt_q <= '0;
            disp_en_q  <= 1'b0;
        end else begin
            disp_cnt_q <= disp_cnt_d;
            disp_en_q  <= disp_en_d;
        end
    end

    assign hash_start = hash_start_q;
    assign hash_time  = hash_time_q;
    assign hash_id    = hash_id_q;
    assign key_out    = key_q;
    assign key_valid  = key_valid_q;
    assign display_en = disp_en_q;
    assign cur_time   = time_q;
    assign epoch_tick = epoch_tick_q;

endmodule

// File: tb/tb_key_refresh_scheduler.sv
// Scoreboard bench for key_refresh_scheduler: request/key queues plus a cycle-count time model.
module tb_key_refresh_scheduler;

    localparam int TICK_DIV      = 4;
    localparam int KEY_PERIOD    = 3;
    localparam int DISPLAY_TICKS = 2;
    localparam int HASH_TIMEOUT  = 8;
    localparam int EPOCH_CYC     = TICK_DIV * KEY_PERIOD;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        button_pulse = 1'b0;
    logic [15:0] student_id = 16'h5A3C;
    logic        hash_done = 1'b0;
    logic [15:0] hash_result = 16'h0000;
    logic        hash_start;
    logic [15:0] hash_time;
    logic [15:0] hash_id;
    logic [15:0] key_out;
    logic        key_valid;
    logic        display_en;
    logic [15:0] cur_time;
    logic        epoch_tick;
    logic        hash_err;

    typedef struct packed {
        logic [15:0] t;
        logic [15:0] id;
    } req_t;

    req_t        req_q[$];
    logic [15:0] key_q[$];
    int          tests = 0;
    int          fails = 0;
    int          n_edge = 0;
    int          n_start = 0;
    logic        prev_start = 1'b0;

    key_refresh_scheduler #(
        .TICK_DIV(TICK_DIV), .KEY_PERIOD(KEY_PERIOD),
        .DISPLAY_TICKS(DISPLAY_TICKS), .HASH_TIMEOUT(HASH_TIMEOUT)
    ) dut (
        .sysclk(sysclk), .reset(reset), .button_pulse(button_pulse),
        .student_id(student_id), .hash_done(hash_done), .hash_result(hash_result),
        .hash_start(hash_start), .hash_time(hash_time), .hash_id(hash_id),
        .key_out(key_out), .key_valid(key_valid), .display_en(display_en),
        .cur_time(cur_time), .epoch_tick(epoch_tick), .hash_err(hash_err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // One clock; samples 1 time unit after the edge and checks time/epoch model and requests.
    task automatic tick();
        req_t        r;
        logic [15:0] exp_t;
        logic        exp_ep;
        @(posedge sysclk);
        #1;
        if (reset) begin
            n_edge = 0;
            prev_start = 1'b0;
            return;
        end
        n_edge++;
        exp_t = 16'(n_edge / TICK_DIV);
        tests++;
        if (cur_time !== exp_t) begin
            fails++;
            $display("FAIL cur_time n=%0d got %0d exp %0d", n_edge, cur_time, exp_t);
        end
        exp_ep = ((n_edge % EPOCH_CYC) == 0);
        tests++;
        if (epoch_tick !== exp_ep) begin
            fails++;
            $display("FAIL epoch_tick n=%0d got %b exp %b", n_edge, epoch_tick, exp_ep);
        end
        if (hash_start === 1'b1) begin
            n_start++;
            tests++;
            if (prev_start) begin
                fails++;
                $display("FAIL hash_start_width n=%0d got 2+ cycles exp 1", n_edge);
            end
            if (req_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_hash_start n=%0d time=%h", n_edge, hash_time);
            end else begin
                r = req_q.pop_front();
                tests++;
                if (hash_time !== r.t || hash_id !== r.id) begin
                    fails++;
                    $display("FAIL req_operands n=%0d got t=%h id=%h exp t=%h id=%h",
                             n_edge, hash_time, hash_id, r.t, r.id);
                end
            end
        end
        prev_start = hash_start;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        button_pulse = 1'b0;
        hash_done = 1'b0;
        tick();
        tick();
        tests++;
        if ({hash_start, epoch_tick, key_valid, display_en, hash_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got %b exp 00000",
                     {hash_start, epoch_tick, key_valid, display_en, hash_err});
        end
        tests++;
        if ({hash_time, hash_id, key_out, cur_time} !== 64'h0) begin
            fails++;
            $display("FAIL reset_words got %h exp 0", {hash_time, hash_id, key_out, cur_time});
        end
        req_q.delete();
        key_q.delete();
        n_start = 0;
        req_q.push_back({16'h0000, student_id});
        reset = 1'b0;
    endtask

    task automatic respond(input int dly, input logic [15:0] val);
        logic [15:0] exp;
        repeat (dly) tick();
        hash_done = 1'b1;
        hash_result = val;
        key_q.push_back(val);
        tick();
        hash_done = 1'b0;
        hash_result = 16'h0000;
        exp = key_q.pop_front();
        tests++;
        if (key_out !== exp || key_valid !== 1'b1) begin
            fails++;
            $display("FAIL key_latch n=%0d got %h/%b exp %h/1", n_edge, key_out, key_valid, exp);
        end
        tests++;
        if (hash_err !== 1'b0) begin
            fails++;
            $display("FAIL hash_err_clear n=%0d got %b exp 0", n_edge, hash_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        tests++;
        if (hash_start !== 1'b1 || hash_time !== 16'h0 || hash_id !== student_id) begin
            fails++;
            $display("FAIL first_request got s=%b t=%h id=%h exp s=1 t=0 id=%h",
                     hash_start, hash_time, hash_id, student_id);
        end
        respond(2, 16'hBEEF);
    endtask

    task automatic test_free_run();
        req_q.push_back({16'd3, student_id});
        while (n_edge < 12) tick();
        tests++;
        if (cur_time !== 16'd3 || epoch_tick !== 1'b1 || n_start !== 1) begin
            fails++;
            $display("FAIL free_run got t=%0d ep=%b starts=%0d exp t=3 ep=1 starts=1",
                     cur_time, epoch_tick, n_start);
        end
        tick();
        tests++;
        if (hash_start !== 1'b1 || hash_time !== 16'd3) begin
            fails++;
            $display("FAIL epoch_request got s=%b t=%0d exp s=1 t=3", hash_start, hash_time);
        end
        respond(2, 16'h1234);
    endtask

    task automatic test_spurious_done();
        do_reset();
        hash_done = 1'b1;
        hash_result = 16'hDEAD;
        tick();
        tick();
        hash_done = 1'b0;
        tests++;
        if (key_valid !== 1'b0 || key_out !== 16'h0) begin
            fails++;
            $display("FAIL done_in_idle_req got %h/%b exp 0000/0", key_out, key_valid);
        end
        respond(0, 16'hC0DE);
    endtask

    task automatic test_display();
        do_reset();
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
        tests++;
        if (display_en !== 1'b0) begin
            fails++;
            $display("FAIL press_before_key got %b exp 0", display_en);
        end
        respond(2, 16'hBEEF);
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
        tests++;
        if (display_en !== 1'b1) begin
            fails++;
            $display("FAIL press_open got %b exp 1", display_en);
        end
        while (n_edge < 11) tick();
        tests++;
        if (display_en !== 1'b1) begin
            fails++;
            $display("FAIL window_hold n=%0d got %b exp 1", n_edge, display_en);
        end
        tick();
        tests++;
        if (display_en !== 1'b0) begin
            fails++;
            $display("FAIL window_close n=%0d got %b exp 0", n_edge, display_en);
        end
    endtask

    task automatic test_display_reload();
        do_reset();
        tick();
        respond(2, 16'hBEEF);
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
        while (n_edge < 11) tick();
        req_q.push_back({16'd3, student_id});
        button_pulse = 1'b1;
        tick();
        button_pulse = 1'b0;
        tests++;
        if (display_en !== 1'b1) begin
            fails++;
            $display("FAIL reload_wins n=%0d got %b exp 1", n_edge, display_en);
        end
        while (n_edge < 19) tick();
        tests++;
        if (display_en !== 1'b1) begin
            fails++;
            $display("FAIL reload_hold n=%0d got %b exp 1", n_edge, display_en);
        end
        tick();
        tests++;
        if (display_en !== 1'b0) begin
            fails++;
            $display("FAIL reload_close n=%0d got %b exp 0", n_edge, display_en);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [15:0] exp;
        do_reset();
        tick();
        respond(2, 16'h1111);
        req_q.push_back({16'd3, student_id});
        while (n_edge < 13) tick();
        base = n_start;
        while (n_edge < 39) tick();
        hash_done = 1'b1;
        hash_result = 16'h2222;
        key_q.push_back(16'h2222);
        req_q.push_back({16'((40 + 1) / TICK_DIV), student_id});
        tick();
        hash_done = 1'b0;
        exp = key_q.pop_front();
        tests++;
        if (key_out !== exp || n_start !== base) begin
            fails++;
            $display("FAIL late_done got key=%h starts=%0d exp key=%h starts=%0d",
                     key_out, n_start, exp, base);
        end
        tick();
        tests++;
        if (hash_start !== 1'b1) begin
            fails++;
            $display("FAIL merged_request n=%0d got %b exp 1", n_edge, hash_start);
        end
        while (n_edge < 47) tick();
        tests++;
        if (n_start !== base + 1) begin
            fails++;
            $display("FAIL merged_count got %0d exp %0d", n_start - base, 1);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        respond(2, 16'hBEEF);
        req_q.push_back({16'd3, student_id});
        while (n_edge < 13) tick();
`ifdef HASH_TIMEOUT_EN
        while (n_edge < 21) tick();
        tests++;
        if (hash_err !== 1'b0) begin
            fails++;
            $display("FAIL err_early n=%0d got %b exp 0", n_edge, hash_err);
        end
        tick();
        tests++;
        if (hash_err !== 1'b1 || key_out !== 16'hBEEF || key_valid !== 1'b1) begin
            fails++;
            $display("FAIL timeout got err=%b key=%h/%b exp 1 BEEF/1", hash_err, key_out, key_valid);
        end
        req_q.push_back({16'd6, student_id});
        while (n_edge < 25) tick();
        tests++;
        if (hash_start !== 1'b1 || hash_err !== 1'b1) begin
            fails++;
            $display("FAIL retry_request got s=%b err=%b exp 1 1", hash_start, hash_err);
        end
        respond(2, 16'h4242);
`else
        while (n_edge < 47) tick();
        tests++;
        if (hash_err !== 1'b0 || key_out !== 16'hBEEF || n_start !== 2) begin
            fails++;
            $display("FAIL no_watchdog got err=%b key=%h starts=%0d exp 0 BEEF 2",
                     hash_err, key_out, n_start);
        end
        req_q.push_back({16'((48 + 1) / TICK_DIV), student_id});
        respond(0, 16'h4242);
        tick();
        tests++;
        if (hash_start !== 1'b1) begin
            fails++;
            $display("FAIL post_wait_request n=%0d got %b exp 1", n_edge, hash_start);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_spurious_done();
        test_display();
        test_display_reload();
        test_back_to_back();
        test_timeout();
        tests++;
        if (req_q.size() != 0) begin
            fails++;
            $display("FAIL missing_requests got %0d left exp 0", req_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
